// File: rtl/mips_cpu_bus_master.sv
// mips_cpu_bus_master
// Turns the core's single-outstanding load/store/fetch requests into
// word-addressed, byte-enabled bus transfers that are held through
// waitrequest stalls. Misaligned requests are answered with an error
// and never reach the bus.
//
// Ports
//   clk, reset                         clock, async active-high reset
//   req_valid/req_ready                core request handshake (ready in IDLE)
//   req_write, req_size, req_signed    store flag, 0=byte 1=half 2/3=word, sign-extend
//   req_addr, req_wdata                byte address, right-justified store data
//   resp_valid, resp_rdata, resp_err   one-cycle response, extended load data, error
//   address, read, write               word-aligned bus address and strobes
//   waitrequest                        slave stall
//   writedata, byteenable, readdata    lane-positioned data, lane enables, slave data
//
// Optional feature: define MIPS_BUS_TIMEOUT_EN to abort a transfer that is
// still stalled after TIMEOUT_CYCLES bus cycles (response with resp_err=1).
module mips_cpu_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_be;
    logic        r_read;
    logic        r_write;
    logic        r_err;
    logic        r_signed;
    logic        r_first;   // first BUS cycle: slave cannot have raised waitrequest yet
    logic [1:0]  r_size;
    logic [1:0]  r_off;

    logic        w_accept;
    logic        w_misal;
    logic        w_done;
    logic        w_tmo;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ext;

    assign w_off    = req_addr[1:0];
    assign w_size   = (req_size == 2'd3) ? 2'd2 : req_size;
    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_done   = (r_state == ST_BUS) && !r_first && !waitrequest;

    // Lane generation and alignment check on the incoming request
    always_comb begin
        w_misal = 1'b0;
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (w_size)
            2'd0: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_misal = w_off[0];
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: w_misal = (w_off != 2'b00);
        endcase
    end

    // Read data: shift the addressed byte down to lane 0, then extend
    assign w_shift = readdata >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'd0:    w_ext = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_ext = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt;

    // r_cnt holds the number of BUS cycles already completed
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= '0;
        else if (r_state == ST_BUS)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_tmo = (r_state == ST_BUS) && !w_done &&
                   (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_tmo            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_misal ? ST_RESP : ST_BUS;
            ST_BUS:  if (w_done || w_tmo) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode; everything driven here comes straight from registers
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = (r_state == ST_RESP);
        resp_rdata = (r_state == ST_RESP) ? r_rdata : '0;
        resp_err   = (r_state == ST_RESP) & r_err;
        address    = r_addr;
        read       = r_read;
        write      = r_write;
        writedata  = r_wdata;
        byteenable = r_be;
    end

    // Request latch, bus strobes and response data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_be     <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_signed <= 1'b0;
            r_first  <= 1'b0;
            r_size   <= '0;
            r_off    <= '0;
        end else if (w_accept) begin
            r_err    <= w_misal;
            r_rdata  <= '0;
            r_size   <= w_size;
            r_off    <= w_off;
            r_signed <= req_signed;
            r_addr   <= {req_addr[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_read   <= !w_misal && !req_write;
            r_write  <= !w_misal && req_write;
            r_first  <= 1'b1;
        end else if (r_state == ST_BUS) begin
            r_first <= 1'b0;
            if (w_done) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                if (r_read)
                    r_rdata <= w_ext;
            end else if (w_tmo) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                r_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Scoreboard bench for mips_cpu_bus_master: stimulus pushes the expected bus
// transfer and response; a slave process plays the bus and checks transfers,
// a monitor process checks responses.
module tb_mips_cpu_bus_master;

    localparam int T = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_seen = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] rdval;
        int unsigned w;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          t;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];

    mips_cpu_bus_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    // Number of cycles the strobe should stay high for a slave that stalls w cycles
    function automatic int unsigned strobe_len(input int unsigned w);
`ifdef MIPS_BUS_TIMEOUT_EN
        if (w >= T) return T;
`endif
        return w + 1;
    endfunction

    // Issue one request; w = stall cycles seen by the master (>=1, first is forced)
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rv, input int unsigned w);
        int unsigned n, off, budget;
        bus_t  b;
        resp_t r;
        logic [31:0] v;
        budget = 0;
        while (!req_ready && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        n   = nbytes(sz);
        off = a[1:0];
        if ((off % n) != 0) begin
            r.err   = 1'b1;
            r.rdata = '0;
            r.t     = cyc + 1;
        end else begin
            b.addr = {a[31:2], 2'b00};
            b.be   = '0;
            for (int i = 0; i < int'(n); i++) b.be[int'(off) + i] = 1'b1;
            for (int x = 0; x < 4; x++)
                b.wdata[8*x +: 8] = wd[8*((x + 4 - int'(off)) % int'(n)) +: 8];
            b.wr    = wr;
            b.rdval = rv;
            b.w     = w;
            bus_q.push_back(b);
            if (strobe_len(w) != w + 1) begin
                r.err   = 1'b1;
                r.rdata = '0;
            end else begin
                r.err = 1'b0;
                v = '0;
                if (!wr) begin
                    for (int i = 0; i < int'(n); i++) v[8*i +: 8] = rv[8*(int'(off) + i) +: 8];
                    if (sg && n < 4 && v[8*n-1])
                        for (int i = int'(n); i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                r.rdata = v;
            end
            r.t = cyc + int'(strobe_len(w)) + 1;
        end
        resp_q.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Bus slave: stalls as scripted and checks each transfer
    initial begin
        bus_t cur;
        bit active;
        int unsigned scyc;
        active      = 0;
        scyc        = 0;
        cur         = '{default: '0};
        waitrequest = 1'b0;
        readdata    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active      = 0;
                waitrequest = 1'b0;
            end else begin
                if (read && write) chk("strobe_overlap", {read, write}, 2'b00);
                if (read || write) begin
                    if (!active) begin
                        active = 1;
                        scyc   = 0;
                        if (bus_q.size() == 0) begin
                            chk("unexpected_strobe", {read, write}, 2'b00);
                            cur = '{default: '0};
                            cur.w = 1;
                        end else begin
                            cur = bus_q.pop_front();
                            chk("bus_write", {31'b0, write}, {31'b0, cur.wr});
                            chk("bus_read", {31'b0, read}, {31'b0, !cur.wr});
                        end
                    end
                    scyc++;
                    chk("bus_address", address, cur.addr);
                    chk("bus_byteenable", {28'b0, byteenable}, {28'b0, cur.be});
                    if (cur.wr) chk("bus_writedata", writedata, cur.wdata);
                    waitrequest = (scyc == 1) ? 1'($urandom_range(0, 1)) : (scyc <= cur.w);
                    readdata    = (scyc == cur.w + 1) ? cur.rdval : $urandom;
                end else begin
                    if (active) begin
                        chk("strobe_length", scyc, strobe_len(cur.w));
                        active = 0;
                    end
                    waitrequest = 1'($urandom_range(0, 1));
                    readdata    = $urandom;
                end
            end
        end
    end

    // Response monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!reset && resp_valid) begin
                resp_seen++;
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_err", {31'b0, resp_err}, {31'b0, r.err});
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_cycle", cyc, r.t);
                    chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int seen0, budget;
        logic [1:0] sz;
        logic [31:0] a;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = '0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_strobes", {30'b0, read, write}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_byteenable", {28'b0, byteenable}, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_resp", {resp_rdata[30:0], resp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(1'b0, 2'd2, 1'b0, 32'hBFC00004, 32'h0, 32'h8C020000, 6);
        issue(1'b0, 2'd0, 1'b1, 32'hBFC00013, 32'h0, 32'h80123456, 3);
        issue(1'b0, 2'd0, 1'b0, 32'hBFC00013, 32'h0, 32'h80123456, 2);
        issue(1'b1, 2'd1, 1'b0, 32'hBFC0000A, 32'h0000BEEF, 32'h0, 2);
        issue(1'b0, 2'd2, 1'b0, 32'hBFC00002, 32'h0, 32'h0, 1);
        issue(1'b0, 2'd3, 1'b1, 32'h00000040, 32'h0, 32'hFEDCBA98, 1);
        issue(1'b1, 2'd2, 1'b0, 32'h00000044, 32'h12345678, 32'h0, 1);
        issue(1'b0, 2'd1, 1'b1, 32'h00000046, 32'h0, 32'h8001_7FFF, 1);

        // Reset while a read is stalled on the bus
        issue(1'b0, 2'd2, 1'b0, 32'h00001000, 32'h0, 32'h0, 20);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_read_drop", {31'b0, read}, 32'd0);
        chk("reset_write_drop", {31'b0, write}, 32'd0);
        resp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        seen0 = resp_seen;
        repeat (20) @(negedge clk);
        chk("reset_no_resp", resp_seen, seen0);

`ifdef MIPS_BUS_TIMEOUT_EN
        issue(1'b0, 2'd2, 1'b0, 32'h00002000, 32'h0, 32'h1234, 300);
`endif

        // Randomized traffic
        for (int k = 0; k < 200; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd0) ? a[1:0] : ((sz == 2'd1) ? {a[1], 1'b0} : 2'b00);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(1, 8));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        budget = 0;
        while (resp_q.size() > 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        chk("resp_queue_drained", resp_q.size(), 32'd0);
        chk("bus_queue_drained", bus_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
